// File: rtl/tcpu_pkg.sv
// Shared types and constants for the tiny-cpu pipeline.
// Fetch-state encoding, NOP encoding and default reset PC.
package tcpu_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: async reset, word-aligned redirect load, +4 step.
// pc4 is the wrapping successor of the current PC.
module fetch_pc_reg
    import tcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    assign pc4 = pc + 32'd4;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc <= {RESET_PC[31:2], 2'b00};
        end else if (load) begin
            pc <= {target[31:2], 2'b00};
        end else if (inc) begin
            pc <= pc4;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, held output.
// Optional IF_FLUSH_CNT_EN adds the if_flush_cnt redirect/discard counter.
module if_fetch
    import tcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        En,
    input  logic        condep,
    input  logic [31:0] redir_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst,
    output logic        if_valid
`ifdef IF_FLUSH_CNT_EN
    ,
    output logic [31:0] if_flush_cnt
`endif
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc4;
    logic [31:0]  ibuf, ibuf_pc4;
    logic         pc_load, accept, req_c;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .Clk    (Clk),
        .Clrn   (Clrn),
        .load   (pc_load),
        .inc    (accept),
        .target (redir_pc),
        .pc     (pc),
        .pc4    (pc4)
    );

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) state <= REQ;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_load   = 1'b0;
        accept    = 1'b0;
        req_c     = 1'b0;
        unique case (state)
            REQ: begin
                req_c = ~condep;
                if (condep)        pc_load   = 1'b1;
                else if (imem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (condep) begin
                    pc_load   = 1'b1;
                    state_nxt = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    accept    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (condep) begin
                    pc_load   = 1'b1;
                    state_nxt = REQ;
                end else if (En) begin
                    req_c     = 1'b1;
                    state_nxt = imem_gnt ? WAIT : REQ;
                end
            end
            DROP: begin
                if (condep)      pc_load   = 1'b1;
                if (imem_rvalid) state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            ibuf     <= NOP_INST;
            ibuf_pc4 <= 32'h0;
        end else if (accept) begin
            ibuf     <= imem_rdata;
            ibuf_pc4 <= pc4;
        end
    end

    // Request is suppressed while reset is asserted even though state is REQ.
    assign imem_req  = req_c & Clrn;
    assign imem_addr = pc;
    assign if_valid  = (state == HOLD);
    assign if_inst   = if_valid ? ibuf : NOP_INST;
    assign if_pc4    = if_valid ? ibuf_pc4 : 32'h0;

`ifdef IF_FLUSH_CNT_EN
    logic discard;

    assign discard = imem_rvalid &
                     (((state == WAIT) & condep) | (state == DROP));

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) if_flush_cnt <= 32'h0;
        else       if_flush_cnt <= if_flush_cnt
                                   + {31'h0, condep}
                                   + {31'h0, discard};
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch against a transaction-level model.
// Memory responder and reference model live in the bench.
module tb_if_fetch;

    logic        Clk = 1'b0;
    logic        Clrn = 1'b0;
    logic        En = 1'b0;
    logic        condep = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic        if_valid;
`ifdef IF_FLUSH_CNT_EN
    logic [31:0] if_flush_cnt;
`endif

    if_fetch dut (
        .Clk         (Clk),
        .Clrn        (Clrn),
        .En          (En),
        .condep      (condep),
        .redir_pc    (redir_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_pc4      (if_pc4),
        .if_inst     (if_inst),
        .if_valid    (if_valid)
`ifdef IF_FLUSH_CNT_EN
        ,
        .if_flush_cnt(if_flush_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: next fetch address, pending request, held entry.
    logic [31:0] m_pc;
    bit          m_pend, m_stale, m_hv;
    logic [31:0] m_hinst, m_hpc4, m_cnt;

    // Memory responder: at most one response scheduled.
    bit          mo_busy;
    logic [31:0] mo_addr;
    int          mo_cnt;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_pend  = 0;
        m_stale = 0;
        m_hv    = 0;
        m_hinst = 32'h0;
        m_hpc4  = 32'h0;
        m_cnt   = 32'h0;
    endtask

    task automatic check_outputs(bit req);
        chk("imem_req", {31'h0, imem_req}, {31'h0, req});
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", {31'h0, if_valid}, {31'h0, m_hv});
        chk("if_inst", if_inst, m_hv ? m_hinst : 32'h0);
        chk("if_pc4", if_pc4, m_hv ? m_hpc4 : 32'h0);
`ifdef IF_FLUSH_CNT_EN
        chk("flush_cnt", if_flush_cnt, m_cnt);
`endif
    endtask

    task automatic cycle(bit en, bit cd, logic [31:0] rpc, bit gnt, int k);
        bit req, rv;
        @(negedge Clk);
        En       = en;
        condep   = cd;
        redir_pc = rpc;
        imem_gnt = gnt;
        rv       = mo_busy && (mo_cnt == 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(mo_addr) : $urandom;
        #1;
        // A new fetch may issue only with nothing in flight and the buffer free or being consumed.
        req = Clrn && !m_pend && (!m_hv || en) && !cd;
        check_outputs(req);
        if (Clrn) begin
            if (rv)           mo_busy = 0;
            else if (mo_busy) mo_cnt--;
            if (req && gnt) begin
                mo_busy = 1;
                mo_addr = m_pc;
                mo_cnt  = k - 1;
            end
            if (cd) begin
                m_cnt++;
                m_pc = rpc & ~32'h3;
                m_hv = 0;
                if (m_pend) begin
                    if (rv) begin
                        m_pend = 0;
                        m_cnt++;
                    end else begin
                        m_stale = 1;
                    end
                end
            end else if (m_pend) begin
                if (rv) begin
                    if (m_stale) begin
                        m_cnt++;
                    end else begin
                        m_hv    = 1;
                        m_hinst = mem_word(m_pc);
                        m_hpc4  = m_pc + 32'd4;
                        m_pc    = m_pc + 32'd4;
                    end
                    m_pend = 0;
                end
            end else if (req) begin
                m_hv = 0;
                if (gnt) begin
                    m_pend  = 1;
                    m_stale = 0;
                end
            end
        end
        @(posedge Clk);
    endtask

    initial begin
        model_reset();
        mo_busy = 0;
        mo_addr = 32'h0;
        mo_cnt  = 0;

        // Held in reset: everything quiet.
        cycle(1, 0, 32'h0, 1, 1);
        cycle(1, 0, 32'h0, 1, 1);
        #2 Clrn = 1'b1;

        // Streaming: addresses 0,4,8...
        repeat (8) cycle(1, 0, 32'h0, 1, 1);

        // Stall in HOLD for 5 cycles, then release.
        for (int i = 0; i < 6 && !m_hv; i++) cycle(1, 0, 32'h0, 1, 1);
        repeat (5) cycle(0, 0, 32'h0, 1, 1);
        repeat (4) cycle(1, 0, 32'h0, 1, 1);

        // Redirect in WAIT to 0x103, response three cycles later.
        for (int i = 0; i < 6 && !m_pend; i++) cycle(1, 0, 32'h0, 1, 4);
        cycle(1, 1, 32'h0000_0103, 0, 1);
        repeat (8) cycle(1, 0, 32'h0, 1, 1);

        // condep and En together in HOLD.
        for (int i = 0; i < 6 && !m_hv; i++) cycle(1, 0, 32'h0, 1, 1);
        cycle(1, 1, 32'h0000_0200, 1, 1);
        repeat (6) cycle(1, 0, 32'h0, 1, 1);

        // Wrap at top of address space.
        for (int i = 0; i < 6 && m_pend; i++) cycle(1, 0, 32'h0, 0, 1);
        cycle(1, 1, 32'hFFFF_FFFC, 1, 1);
        repeat (8) cycle(1, 0, 32'h0, 1, 1);

        // Randomized traffic.
        repeat (3000) begin
            cycle($urandom_range(3, 0) != 0,
                  $urandom_range(9, 0) == 0,
                  $urandom,
                  $urandom_range(1, 0) == 1,
                  $urandom_range(4, 1));
        end

        // Reset pulsed while a request is outstanding.
        for (int i = 0; i < 6 && !m_pend; i++) cycle(1, 0, 32'h0, 1, 6);
        @(negedge Clk);
        En = 1'b1;
        condep = 1'b0;
        #2 Clrn = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0);
        @(posedge Clk);
        @(posedge Clk);
        #2 Clrn = 1'b1;
        // Stale response lands while in REQ with no grant: must be ignored.
        mo_cnt = 0;
        cycle(1, 0, 32'h0, 0, 1);
        repeat (10) cycle(1, 0, 32'h0, 1, 1);
        repeat (200) begin
            cycle($urandom_range(3, 0) != 0,
                  $urandom_range(9, 0) == 0,
                  $urandom,
                  $urandom_range(1, 0) == 1,
                  $urandom_range(3, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the tiny-cpu pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter, issues split-phase requests to instruction memory (one outstanding at a time), and holds the returned instruction with its PC+4 until the pipeline consumes it. It accepts stall (`En`) and redirect (`condep` + target) from ID/hazard logic and drops in-flight responses made stale by a redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- `Clk`  in  1  the single clock; all state changes on posedge.
- `Clrn`  in  1  asynchronous, active-low reset.
- `En`  in  1  pipeline advance enable (same signal driving IF/ID `En`); 0 = stall.
- `condep`  in  1  redirect: taken branch/jump resolved in ID; priority over `En`.
- `redir_pc`  in  32  redirect target; bits [1:0] forced to 0 internally.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request address (= PC).
- `imem_gnt`  in  1  request accepted in a cycle where `imem_req`=1.
- `imem_rvalid`  in  1  response valid; at most one per accepted request, ≥1 cycle after grant.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `if_pc4`  out  32  PC+4 of held instruction (feeds IF/ID `D0`).
- `if_inst`  out  32  held instruction, 32'h0 (NOP) when `if_valid`=0 (feeds IF/ID `D1`).
- `if_valid`  out  1  held instruction present.

## Operation
- States: REQ, WAIT, HOLD, DROP. Registers: `pc`, `ibuf`, `ibuf_pc4`, state.
- REQ: `imem_req`=~`condep`, `imem_addr`=`pc`. `condep` → `pc`<=`redir_pc`, stay REQ. Else `imem_gnt` → WAIT.
- WAIT: `condep` → `pc`<=`redir_pc`; if `imem_rvalid` same cycle, discard, → REQ; else → DROP. Else `imem_rvalid` → `ibuf`<=`imem_rdata`, `ibuf_pc4`<=`pc`+4, `pc`<=`pc`+4, → HOLD.
- HOLD: `if_valid`=1. `condep` → invalidate, `pc`<=`redir_pc`, → REQ. Else `En`=1 → consumed this cycle; same cycle `imem_req`=1 at `pc`; `imem_gnt` → WAIT, else → REQ. `En`=0 → stay, no request.
- DROP: `imem_req`=0; wait `imem_rvalid`, discard data, → REQ. `condep` in DROP updates `pc`, stays DROP.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- `if_valid`=1 only in HOLD; `if_inst`/`if_pc4` are 0 otherwise.

## Timing
- Reset (async, `Clrn`=0): state REQ, `pc`=`RESET_PC`, `ibuf`=0, `ibuf_pc4`=0; outputs `imem_req`=0 while `Clrn`=0, `if_valid`=0, `if_inst`=0, `if_pc4`=0. First request in the first cycle after release.
- Reset mid-WAIT: outstanding response after release ignored only if it arrives while in REQ (no request granted); responses are never accepted outside WAIT/DROP.
- Latency: grant at cycle t, `imem_rvalid` at t+k (k≥1) → `if_valid` at t+k+1.
- Throughput with k=1 and `imem_gnt` tied 1: one instruction per 2 cycles.
- `imem_req`/`imem_addr` combinational from state, `pc`, `En`, `condep`; no combinational path from `imem_rvalid` to any output.
- Simultaneous `condep` and `En`: `condep` wins, held instruction discarded.

## Configuration
- `IF_FLUSH_CNT_EN`: defined → extra output `if_flush_cnt` (32, out): counts cycles with `condep`=1, plus one per discarded response; reset 0, wraps at 2^32. Undefined → port and counter absent; behaviour otherwise identical.

## Structure
- Package `tcpu_pkg`: fetch-state enum (REQ/WAIT/HOLD/DROP), `NOP_INST`=32'h0, default `RESET_PC`.
- One natural sub-module: `fetch_pc_reg` — PC register with async reset, redirect load (low bits masked), +4 increment.

## Test plan
- Reset release, `imem_gnt`=1, rvalid k=1, `En`=1: addresses 0x0,0x4,0x8; `if_inst` matches memory, `if_pc4` = 0x4,0x8,0xC.
- `En`=0 for 5 cycles in HOLD: `if_inst`/`if_pc4` stable, `imem_req`=0; `En`=1 → request to next PC same cycle.
- `condep`=1 with `redir_pc`=0x103 in WAIT, rvalid 3 cycles later: response discarded (DROP), next request to 0x100, `if_valid` never shows stale word.
- `condep` and `En` both 1 in HOLD: instruction dropped, next request at `redir_pc`.
- PC 0xFFFF_FFFC fetched: `if_pc4`=0, next request address 0x0.
- `Clrn` pulsed low in WAIT: outputs immediately 0, `imem_req`=0; after release request to `RESET_PC`; with `IF_FLUSH_CNT_EN`, counter reads 0.
